multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Moore FSM for the multi-cycle MIPS datapath; drives the ALU through alu_fun/sign and steers operands, memory, PC, regfile.
//  Decodes the latched instruction word and walks FETCH/DECODE/EXEC/MEM/WB, stalling on a memory ready handshake.
// PARAMETERS
//  (none)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  instr        in   32  instruction register contents (valid from DECODE onward)
//  mem_ready    in   1   memory completed the current mem_read/mem_write this cycle
//  cmp_true     in   1   ALU result bit 0 (compare outcome), same cycle
//  state        out  4   current state encoding (debug)
//  pc_write     out  1   load PC (gated by cmp_true in BRANCH)
//  pc_src       out  2   0=ALU result,1=ALUOut reg,2={PC[31:28],instr[25:0],2'b0},3=rs
//  i_or_d       out  1   memory address: 0=PC, 1=ALUOut
//  mem_read     out  1   memory read strobe
//  mem_write    out  1   memory write strobe
//  ir_write     out  1   load instruction register
//  reg_write    out  1   regfile write enable
//  reg_dst      out  2   0=rt, 1=rd, 2=$31
//  mem_to_reg   out  2   0=ALUOut, 1=MDR, 2=PC
//  alu_src_a    out  2   0=PC, 1=rs, 2=shamt zero-extended
//  alu_src_b    out  2   0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2
//  ext_op       out  1   1=sign-extend imm, 0=zero-extend
//  lu_op        out  1   1=imm path yields {imm,16'b0}
//  alu_fun      out  6   ALU operation code
//  sign         out  1   1=signed compare/overflow semantics
//  illegal_op   out  1   one-cycle pulse: undecodable instruction
// BEHAVIOUR
//  ALU codes: ADD 000000 SUB 000001 AND 011000 OR 011110 XOR 010110 NOR 010001 SLL 100000 SRL 100001
//   SRA 100011 EQ 110011 NEQ 110001 LT 110101 LEZ 111101 LTZ 111011 GTZ 111111.
//  States: INIT0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXR7 RWB8 EXI9 IWB10 BRANCH11 JUMP12 JREG13.
//  reset high: state=INIT at once (async), every output 0 incl. in-flight mem_write. INIT -> FETCH next edge.
//  Outputs are pure functions of state + instr; unlisted outputs are 0 in each state.
//  FETCH: i_or_d=0,mem_read,src_a=0,src_b=1,ADD; if mem_ready: ir_write,pc_write,pc_src=0 -> DECODE, else hold.
//  DECODE: src_a=0,src_b=3,ext_op=1,ADD (branch target into ALUOut). Next by opcode/funct:
//   lw/sw->MEMADR; R-arith/shift->EXR; jr/jalr->JREG; I-arith/lui->EXI; beq/bne/blez/bgtz/bltz->BRANCH;
//   j/jal->JUMP; else illegal_op=1 -> FETCH.
//  MEMADR: src_a=1,src_b=2,ext_op=1,ADD; lw->MEMRD, sw->MEMWR.
//  MEMRD: i_or_d=1,mem_read; hold until mem_ready -> MEMWB. MEMWB: reg_write,reg_dst=0,mem_to_reg=1 -> FETCH.
//  MEMWR: i_or_d=1,mem_write; hold until mem_ready -> FETCH.
//  EXR: src_a=1 (2 for sll/srl/sra), src_b=0; funct add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra
//   -> ADD/ADD/SUB/SUB/AND/OR/XOR/NOR/LT/LT/SLL/SRL/SRA; sign=1 for add,sub,slt only. -> RWB.
//  RWB: reg_write,reg_dst=1,mem_to_reg=0 -> FETCH.
//  EXI: src_a=1,src_b=2; addi/addiu/slti/sltiu/andi/ori/lui -> ADD/ADD/LT/LT/AND/OR/ADD;
//   ext_op=0 for andi/ori else 1; sign=1 for addi,slti; lu_op=1 for lui. -> IWB. IWB: reg_write,reg_dst=0 -> FETCH.
//  BRANCH: src_a=1,src_b=0,sign=1; beq EQ, bne NEQ, blez LEZ, bgtz GTZ, bltz(op 000001,rt=0) LTZ;
//   pc_src=1, pc_write=cmp_true. -> FETCH.
//  JUMP: pc_write,pc_src=2; jal also reg_write,reg_dst=2,mem_to_reg=2 (PC already PC+4). -> FETCH.
//  JREG: pc_write,pc_src=3; jalr also reg_write,reg_dst=1,mem_to_reg=2. -> FETCH.
//  Cycles at mem_ready=1: R/I/sw 4, lw 5, branch/jump 3; each extra mem_ready=0 cycle adds one.
//  Overflow not trapped. illegal_op never coincides with any strobe.
// TESTING
//  reset pulse mid-MEMWR with mem_write=1 -> mem_write=0 same cycle, state=INIT, FETCH one edge after release.
//  add $3,$1,$2 (0x00221820), mem_ready=1 -> states 1,2,7,8; EXR alu_fun=000000 sign=1; RWB reg_dst=1 reg_write=1.
//  lw 0x8C220004, mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles, then MEMWB reg_dst=0 mem_to_reg=1.
//  beq 0x10220003 with cmp_true=0 then =1 -> BRANCH alu_fun=110011, pc_write equals cmp_true, pc_src=1.
//  jal 0x0C000010 -> JUMP pc_src=2 reg_dst=2 mem_to_reg=2 reg_write=1; sll 0x00021080 -> src_a=2 alu_fun=100000.
//  opcode 0x3F word 0xFC000000 -> illegal_op 1 cycle in DECODE, no strobes, back to FETCH.

Source files
------------

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller and its datapath.
// The controller takes the master side; the datapath (or a bench) takes the slave side.
interface multi_cycle_ctrl_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        cmp_true;
  logic [3:0]  state;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_op;
  logic        lu_op;
  logic [5:0]  alu_fun;
  logic        sign;
  logic        illegal_op;

  modport master (
    input  instr, mem_ready, cmp_true,
    output state, pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
           lu_op, alu_fun, sign, illegal_op
  );

  modport slave (
    output instr, mem_ready, cmp_true,
    input  state, pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, ext_op,
           lu_op, alu_fun, sign, illegal_op
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath: decodes the latched
// instruction and sequences fetch/decode/execute/memory/writeback steps.
module multi_cycle_ctrl (
  input  logic                clk,
  input  logic                reset,
  multi_cycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXR    = 4'd7,
    RWB    = 4'd8,
    EXI    = 4'd9,
    IWB    = 4'd10,
    BRANCH = 4'd11,
    JUMP   = 4'd12,
    JREG   = 4'd13
  } state_t;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic       lu_op;
    logic [5:0] alu_fun;
    logic       sign;
  } ctrl_t;

  state_t state, nxt;
  ctrl_t  ctrl_q, ctrl_d;

  logic [5:0] opcode, funct;
  logic [4:0] rt;
  assign opcode = bus.instr[31:26];
  assign funct  = bus.instr[5:0];
  assign rt     = bus.instr[20:16];

  logic       r_ok, r_shift, r_sign;
  logic [5:0] r_fun;
  logic       i_ok, i_ext, i_sign, i_lu;
  logic [5:0] i_fun;
  logic       b_ok;
  logic [5:0] b_fun;
  logic       is_mem, is_lw, is_jreg, is_jalr, is_jump, is_jal, legal;

  always_comb begin
    r_ok = '0; r_shift = '0; r_sign = '0; r_fun = ALU_ADD;
    if (opcode == 6'b000000) begin
      case (funct)
        6'b100000: begin r_ok = '1; r_sign = '1; end
        6'b100001: r_ok = '1;
        6'b100010: begin r_ok = '1; r_sign = '1; r_fun = ALU_SUB; end
        6'b100011: begin r_ok = '1; r_fun = ALU_SUB; end
        6'b100100: begin r_ok = '1; r_fun = ALU_AND; end
        6'b100101: begin r_ok = '1; r_fun = ALU_OR; end
        6'b100110: begin r_ok = '1; r_fun = ALU_XOR; end
        6'b100111: begin r_ok = '1; r_fun = ALU_NOR; end
        6'b101010: begin r_ok = '1; r_sign = '1; r_fun = ALU_LT; end
        6'b101011: begin r_ok = '1; r_fun = ALU_LT; end
        6'b000000: begin r_ok = '1; r_shift = '1; r_fun = ALU_SLL; end
        6'b000010: begin r_ok = '1; r_shift = '1; r_fun = ALU_SRL; end
        6'b000011: begin r_ok = '1; r_shift = '1; r_fun = ALU_SRA; end
        default: ;
      endcase
    end
  end

  always_comb begin
    i_ok = '0; i_ext = '1; i_sign = '0; i_lu = '0; i_fun = ALU_ADD;
    b_ok = '0; b_fun = ALU_EQ;
    case (opcode)
      6'b001000: begin i_ok = '1; i_sign = '1; end
      6'b001001: i_ok = '1;
      6'b001010: begin i_ok = '1; i_sign = '1; i_fun = ALU_LT; end
      6'b001011: begin i_ok = '1; i_fun = ALU_LT; end
      6'b001100: begin i_ok = '1; i_ext = '0; i_fun = ALU_AND; end
      6'b001101: begin i_ok = '1; i_ext = '0; i_fun = ALU_OR; end
      6'b001111: begin i_ok = '1; i_lu = '1; end
      6'b000100: b_ok = '1;
      6'b000101: begin b_ok = '1; b_fun = ALU_NEQ; end
      6'b000110: begin b_ok = '1; b_fun = ALU_LEZ; end
      6'b000111: begin b_ok = '1; b_fun = ALU_GTZ; end
      6'b000001: begin b_ok = (rt == 5'd0); b_fun = ALU_LTZ; end
      default: ;
    endcase
  end

  assign is_lw   = (opcode == 6'b100011);
  assign is_mem  = is_lw || (opcode == 6'b101011);
  assign is_jalr = (opcode == 6'b000000) && (funct == 6'b001001);
  assign is_jreg = is_jalr || ((opcode == 6'b000000) && (funct == 6'b001000));
  assign is_jal  = (opcode == 6'b000011);
  assign is_jump = is_jal || (opcode == 6'b000010);
  assign legal   = is_mem || r_ok || is_jreg || i_ok || b_ok || is_jump;

  always_comb begin
    nxt = INIT;
    case (state)
      INIT:   nxt = FETCH;
      FETCH:  nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        if      (is_mem)  nxt = MEMADR;
        else if (r_ok)    nxt = EXR;
        else if (is_jreg) nxt = JREG;
        else if (i_ok)    nxt = EXI;
        else if (b_ok)    nxt = BRANCH;
        else if (is_jump) nxt = JUMP;
        else              nxt = FETCH;
      end
      MEMADR: nxt = is_lw ? MEMRD : MEMWR;
      MEMRD:  nxt = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = bus.mem_ready ? FETCH : MEMWR;
      EXR:    nxt = RWB;
      EXI:    nxt = IWB;
      MEMWB, RWB, IWB, BRANCH, JUMP, JREG: nxt = FETCH;
      default: nxt = INIT;
    endcase
  end

  // Outputs are registered from the state being entered, using the instruction
  // visible while leaving the previous state (IR is stable from DECODE on).
  always_comb begin
    ctrl_d = '0;
    case (nxt)
      FETCH:  begin ctrl_d.mem_read = '1; ctrl_d.alu_src_b = 2'd1; end
      DECODE: begin ctrl_d.alu_src_b = 2'd3; ctrl_d.ext_op = '1; end
      MEMADR: begin
        ctrl_d.alu_src_a = 2'd1; ctrl_d.alu_src_b = 2'd2; ctrl_d.ext_op = '1;
      end
      MEMRD:  begin ctrl_d.i_or_d = '1; ctrl_d.mem_read = '1; end
      MEMWB:  begin ctrl_d.reg_write = '1; ctrl_d.mem_to_reg = 2'd1; end
      MEMWR:  begin ctrl_d.i_or_d = '1; ctrl_d.mem_write = '1; end
      EXR: begin
        ctrl_d.alu_src_a = r_shift ? 2'd2 : 2'd1;
        ctrl_d.alu_fun   = r_fun;
        ctrl_d.sign      = r_sign;
      end
      RWB:    begin ctrl_d.reg_write = '1; ctrl_d.reg_dst = 2'd1; end
      EXI: begin
        ctrl_d.alu_src_a = 2'd1; ctrl_d.alu_src_b = 2'd2;
        ctrl_d.ext_op = i_ext; ctrl_d.lu_op = i_lu;
        ctrl_d.alu_fun = i_fun; ctrl_d.sign = i_sign;
      end
      IWB:    ctrl_d.reg_write = '1;
      BRANCH: begin
        ctrl_d.alu_src_a = 2'd1; ctrl_d.sign = '1;
        ctrl_d.pc_src = 2'd1; ctrl_d.alu_fun = b_fun;
      end
      JUMP: begin
        ctrl_d.pc_write = '1; ctrl_d.pc_src = 2'd2;
        if (is_jal) begin
          ctrl_d.reg_write = '1; ctrl_d.reg_dst = 2'd2; ctrl_d.mem_to_reg = 2'd2;
        end
      end
      JREG: begin
        ctrl_d.pc_write = '1; ctrl_d.pc_src = 2'd3;
        if (is_jalr) begin
          ctrl_d.reg_write = '1; ctrl_d.reg_dst = 2'd1; ctrl_d.mem_to_reg = 2'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= INIT;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_d;
    end
  end

  // Handshake-qualified strobes must react in the same cycle, so they are
  // gated from the live state rather than registered.
  logic fetch_done;
  assign fetch_done = (state == FETCH) && bus.mem_ready;

  assign bus.state      = state;
  assign bus.pc_write   = ctrl_q.pc_write || fetch_done || ((state == BRANCH) && bus.cmp_true);
  assign bus.ir_write   = fetch_done;
  assign bus.illegal_op = (state == DECODE) && !legal;
  assign bus.pc_src     = ctrl_q.pc_src;
  assign bus.i_or_d     = ctrl_q.i_or_d;
  assign bus.mem_read   = ctrl_q.mem_read;
  assign bus.mem_write  = ctrl_q.mem_write;
  assign bus.reg_write  = ctrl_q.reg_write;
  assign bus.reg_dst    = ctrl_q.reg_dst;
  assign bus.mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.alu_src_a  = ctrl_q.alu_src_a;
  assign bus.alu_src_b  = ctrl_q.alu_src_b;
  assign bus.ext_op     = ctrl_q.ext_op;
  assign bus.lu_op      = ctrl_q.lu_op;
  assign bus.alu_fun    = ctrl_q.alu_fun;
  assign bus.sign       = ctrl_q.sign;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Table-driven bench for multi_cycle_ctrl: one vector per clock cycle with
// hand-computed outputs, plus a reset-during-store sequence.
module tb_multi_cycle_ctrl;

  localparam int F_ADD = 32'b000000;
  localparam int F_SUB = 32'b000001;
  localparam int F_AND = 32'b011000;
  localparam int F_OR  = 32'b011110;
  localparam int F_NOR = 32'b010001;
  localparam int F_SLL = 32'b100000;
  localparam int F_SRA = 32'b100011;
  localparam int F_EQ  = 32'b110011;
  localparam int F_NEQ = 32'b110001;
  localparam int F_LT  = 32'b110101;
  localparam int F_LEZ = 32'b111101;
  localparam int F_LTZ = 32'b111011;
  localparam int F_GTZ = 32'b111111;

  typedef struct {
    string       nm;
    logic [31:0] ins;
    logic        rdy;
    logic        cmp;
    logic [29:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  vec_t vq[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [29:0] actual();
    return {bus.state, bus.pc_write, bus.pc_src, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst,
            bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.ext_op,
            bus.lu_op, bus.alu_fun, bus.sign, bus.illegal_op};
  endfunction

  // Field order: state pc_write pc_src i_or_d mem_read mem_write ir_write
  // reg_write reg_dst mem_to_reg alu_src_a alu_src_b ext_op lu_op alu_fun sign illegal_op
  function automatic vec_t mk(string nm, logic [31:0] ins, int rdy, int cmp,
      int st, int pcw, int pcs, int iod, int mr, int mw, int irw, int rw,
      int rd, int m2r, int sa, int sb, int ext, int lu, int fun, int sg, int ill);
    vec_t v;
    v.nm  = nm;
    v.ins = ins;
    v.rdy = 1'(rdy);
    v.cmp = 1'(cmp);
    v.exp = {4'(st), 1'(pcw), 2'(pcs), 1'(iod), 1'(mr), 1'(mw), 1'(irw),
             1'(rw), 2'(rd), 2'(m2r), 2'(sa), 2'(sb), 1'(ext), 1'(lu),
             6'(fun), 1'(sg), 1'(ill)};
    return v;
  endfunction

  task automatic fd(string nm, logic [31:0] ins);
    vq.push_back(mk({nm, ".fetch"},  ins, 1, 0, 1, 1,0,0,1,0,1,0,0,0,0,1,0,0,F_ADD,0,0));
    vq.push_back(mk({nm, ".decode"}, ins, 1, 1, 2, 0,0,0,0,0,0,0,0,0,0,3,1,0,F_ADD,0,0));
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic rwb(string nm, logic [31:0] ins);
    vq.push_back(mk({nm, ".rwb"}, ins, 1, 1, 8, 0,0,0,0,0,0,1,1,0,0,0,0,0,F_ADD,0,0));
  endtask

  task automatic iwb(string nm, logic [31:0] ins);
    vq.push_back(mk({nm, ".iwb"}, ins, 1, 1, 10, 0,0,0,0,0,0,1,0,0,0,0,0,0,F_ADD,0,0));
  endtask

  initial begin
    vq.push_back(mk("init", 32'h0, 1, 1, 0, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    fd("add", 32'h00221820);
    vq.push_back(mk("add.exr", 32'h00221820, 1, 1, 7, 0,0,0,0,0,0,0,0,0,1,0,0,0,F_ADD,1,0));
    rwb("add", 32'h00221820);
    vq.push_back(mk("lw.fetch_stall", 32'h8C220004, 0, 0, 1, 0,0,0,1,0,0,0,0,0,0,1,0,0,F_ADD,0,0));
    fd("lw", 32'h8C220004);
    vq.push_back(mk("lw.memadr", 32'h8C220004, 1, 0, 3, 0,0,0,0,0,0,0,0,0,1,2,1,0,F_ADD,0,0));
    vq.push_back(mk("lw.memrd0", 32'h8C220004, 0, 1, 4, 0,0,1,1,0,0,0,0,0,0,0,0,0,F_ADD,0,0));
    vq.push_back(mk("lw.memrd1", 32'h8C220004, 0, 0, 4, 0,0,1,1,0,0,0,0,0,0,0,0,0,F_ADD,0,0));
    vq.push_back(mk("lw.memrd2", 32'h8C220004, 1, 0, 4, 0,0,1,1,0,0,0,0,0,0,0,0,0,F_ADD,0,0));
    vq.push_back(mk("lw.memwb", 32'h8C220004, 1, 0, 5, 0,0,0,0,0,0,1,0,1,0,0,0,0,F_ADD,0,0));
    fd("sw", 32'hAC220004);
    vq.push_back(mk("sw.memadr", 32'hAC220004, 1, 0, 3, 0,0,0,0,0,0,0,0,0,1,2,1,0,F_ADD,0,0));
    vq.push_back(mk("sw.memwr", 32'hAC220004, 1, 0, 6, 0,0,1,0,1,0,0,0,0,0,0,0,0,F_ADD,0,0));
    fd("beq0", 32'h10220003);
    vq.push_back(mk("beq0.branch", 32'h10220003, 1, 0, 11, 0,1,0,0,0,0,0,0,0,1,0,0,0,F_EQ,1,0));
    fd("beq1", 32'h10220003);
    vq.push_back(mk("beq1.branch", 32'h10220003, 1, 1, 11, 1,1,0,0,0,0,0,0,0,1,0,0,0,F_EQ,1,0));
    fd("bne", 32'h14220003);
    vq.push_back(mk("bne.branch", 32'h14220003, 1, 1, 11, 1,1,0,0,0,0,0,0,0,1,0,0,0,F_NEQ,1,0));
    fd("bltz", 32'h04200002);
    vq.push_back(mk("bltz.branch", 32'h04200002, 1, 0, 11, 0,1,0,0,0,0,0,0,0,1,0,0,0,F_LTZ,1,0));
    fd("blez", 32'h18200002);
    vq.push_back(mk("blez.branch", 32'h18200002, 1, 1, 11, 1,1,0,0,0,0,0,0,0,1,0,0,0,F_LEZ,1,0));
    fd("bgtz", 32'h1C200002);
    vq.push_back(mk("bgtz.branch", 32'h1C200002, 1, 0, 11, 0,1,0,0,0,0,0,0,0,1,0,0,0,F_GTZ,1,0));
    fd("jal", 32'h0C000010);
    vq.push_back(mk("jal.jump", 32'h0C000010, 1, 0, 12, 1,2,0,0,0,0,1,2,2,0,0,0,0,F_ADD,0,0));
    fd("j", 32'h08000010);
    vq.push_back(mk("j.jump", 32'h08000010, 1, 0, 12, 1,2,0,0,0,0,0,0,0,0,0,0,0,F_ADD,0,0));
    fd("jr", 32'h03E00008);
    vq.push_back(mk("jr.jreg", 32'h03E00008, 1, 0, 13, 1,3,0,0,0,0,0,0,0,0,0,0,0,F_ADD,0,0));
    fd("jalr", 32'h00201809);
    vq.push_back(mk("jalr.jreg", 32'h00201809, 1, 0, 13, 1,3,0,0,0,0,1,1,2,0,0,0,0,F_ADD,0,0));
    fd("sll", 32'h00021080);
    vq.push_back(mk("sll.exr", 32'h00021080, 1, 0, 7, 0,0,0,0,0,0,0,0,0,2,0,0,0,F_SLL,0,0));
    rwb("sll", 32'h00021080);
    fd("sra", 32'h00021083);
    vq.push_back(mk("sra.exr", 32'h00021083, 1, 0, 7, 0,0,0,0,0,0,0,0,0,2,0,0,0,F_SRA,0,0));
    rwb("sra", 32'h00021083);
    fd("sub", 32'h00221822);
    vq.push_back(mk("sub.exr", 32'h00221822, 1, 0, 7, 0,0,0,0,0,0,0,0,0,1,0,0,0,F_SUB,1,0));
    rwb("sub", 32'h00221822);
    fd("sltu", 32'h0022182B);
    vq.push_back(mk("sltu.exr", 32'h0022182B, 1, 0, 7, 0,0,0,0,0,0,0,0,0,1,0,0,0,F_LT,0,0));
    rwb("sltu", 32'h0022182B);
    fd("nor", 32'h00221827);
    vq.push_back(mk("nor.exr", 32'h00221827, 1, 0, 7, 0,0,0,0,0,0,0,0,0,1,0,0,0,F_NOR,0,0));
    rwb("nor", 32'h00221827);
    fd("ori", 32'h34220005);
    vq.push_back(mk("ori.exi", 32'h34220005, 1, 0, 9, 0,0,0,0,0,0,0,0,0,1,2,0,0,F_OR,0,0));
    iwb("ori", 32'h34220005);
    fd("andi", 32'h30220005);
    vq.push_back(mk("andi.exi", 32'h30220005, 1, 0, 9, 0,0,0,0,0,0,0,0,0,1,2,0,0,F_AND,0,0));
    iwb("andi", 32'h30220005);
    fd("lui", 32'h3C021234);
    vq.push_back(mk("lui.exi", 32'h3C021234, 1, 0, 9, 0,0,0,0,0,0,0,0,0,1,2,1,1,F_ADD,0,0));
    iwb("lui", 32'h3C021234);
    fd("slti", 32'h28220005);
    vq.push_back(mk("slti.exi", 32'h28220005, 1, 0, 9, 0,0,0,0,0,0,0,0,0,1,2,1,0,F_LT,1,0));
    iwb("slti", 32'h28220005);
    vq.push_back(mk("ill3f.fetch", 32'hFC000000, 1, 0, 1, 1,0,0,1,0,1,0,0,0,0,1,0,0,F_ADD,0,0));
    vq.push_back(mk("ill3f.decode", 32'hFC000000, 1, 0, 2, 0,0,0,0,0,0,0,0,0,0,3,1,0,F_ADD,0,1));
    vq.push_back(mk("illrt.fetch", 32'h04210002, 1, 0, 1, 1,0,0,1,0,1,0,0,0,0,1,0,0,F_ADD,0,0));
    vq.push_back(mk("illrt.decode", 32'h04210002, 1, 0, 2, 0,0,0,0,0,0,0,0,0,0,3,1,0,F_ADD,0,1));
    vq.push_back(mk("illfn.fetch", 32'h0000003F, 1, 0, 1, 1,0,0,1,0,1,0,0,0,0,1,0,0,F_ADD,0,0));
    vq.push_back(mk("illfn.decode", 32'h0000003F, 1, 0, 2, 0,0,0,0,0,0,0,0,0,0,3,1,0,F_ADD,0,1));
    vq.push_back(mk("after_ill.fetch", 32'h00000000, 0, 0, 1, 0,0,0,1,0,0,0,0,0,0,1,0,0,F_ADD,0,0));

    reset = 1'b1;
    bus.instr = '0;
    bus.mem_ready = 1'b0;
    bus.cmp_true = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(actual()), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bus.instr     = vq[i].ins;
      bus.mem_ready = vq[i].rdy;
      bus.cmp_true  = vq[i].cmp;
      #1;
      check(vq[i].nm, 32'(actual()), 32'(vq[i].exp));
      @(posedge clk);
      #1;
    end

    // Reset while a store is stalled with mem_write high.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.instr = 32'hAC220004;
    bus.mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    #1;
    check("memwr.state", 32'(bus.state), 32'd6);
    check("memwr.mem_write", 32'(bus.mem_write), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async.mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_async.outputs", 32'(actual()), 32'h0);
    @(posedge clk);
    #2;
    check("rst_held.state", 32'(bus.state), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release.state", 32'(bus.state), 32'd0);
    @(posedge clk);
    #1;
    check("rst_release.fetch", 32'(bus.state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
